// File: rtl/lane_seq_pkg.sv
// Shared types and constants for the staggered four-lane sequence generator.
package lane_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam int FILL_DEPTH = 3;
    localparam int STEP_CNT_W = 16;

    function automatic logic [STEP_CNT_W-1:0] satInc(input logic [STEP_CNT_W-1:0] value);
        return (value == '1) ? value : value + STEP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/lane_step_timer.sv
// Reloadable down counter that paces lane steps; at_zero_o marks a step opportunity.
module lane_step_timer #(
    parameter int STEP_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic reload_i,
    input  logic freeze_i,
    output logic at_zero_o
);

    localparam int TW = (STEP_CYCLES < 2) ? 1 : $clog2(STEP_CYCLES + 1);
    localparam logic [TW-1:0] RELOAD = TW'(STEP_CYCLES - 1);

    logic [TW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (reload_i) begin
            count_q <= RELOAD;
        end else if (!freeze_i && (count_q != '0)) begin
            count_q <= count_q - TW'(1);
        end
    end

    assign at_zero_o = (count_q == '0);

endmodule

// File: rtl/lane_seq_gen.sv
// Staggered counting source: lane a counts per step, older values shift a->b->c->d,
// snapshots offered with valid/ready and the cadence frozen under back-pressure.
module lane_seq_gen
    import lane_seq_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int INIT        = 5,
    parameter int STEP_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      a,
    output logic [WIDTH-1:0]      b,
    output logic [WIDTH-1:0]      c,
    output logic [WIDTH-1:0]      d,
    output logic                  out_valid,
    output logic                  busy,
    output logic [STEP_CNT_W-1:0] step_count
);

    state_e                state_q;
    logic [1:0]            fill_q;
    logic [WIDTH-1:0]      a_q, b_q, c_q, d_q;
    logic                  valid_q;
    logic [STEP_CNT_W-1:0] stepCount_q;

    logic atZero;
    logic startEn;
    logic stepEn;

    assign startEn = (state_q == IDLE) && start;
    // A pending stop suppresses the step so the lanes hold what the consumer last saw.
    assign stepEn  = (state_q != IDLE) && !stop && atZero && (!valid_q || out_ready);

    lane_step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .reload_i (startEn || stepEn),
        .freeze_i (state_q == IDLE),
        .at_zero_o(atZero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fill_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            valid_q     <= 1'b0;
            stepCount_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= FILL;
                        fill_q      <= '0;
                        a_q         <= WIDTH'(INIT);
                        b_q         <= '0;
                        c_q         <= '0;
                        d_q         <= '0;
                        valid_q     <= 1'b0;
                        stepCount_q <= '0;
                    end
                end
                FILL, RUN: begin
                    if (stop) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end else if (stepEn) begin
                        a_q         <= a_q + WIDTH'(1);
                        b_q         <= a_q;
                        c_q         <= b_q;
                        d_q         <= c_q;
                        stepCount_q <= satInc(stepCount_q);
                        if (state_q == RUN) begin
                            valid_q <= 1'b1;
                        end else if (fill_q == 2'(FILL_DEPTH - 1)) begin
                            state_q <= RUN;
                            valid_q <= 1'b1;
                        end else begin
                            fill_q <= fill_q + 2'd1;
                        end
                    end else if ((state_q == RUN) && valid_q && out_ready) begin
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign a          = a_q;
    assign b          = b_q;
    assign c          = c_q;
    assign d          = d_q;
    assign out_valid  = valid_q;
    assign busy       = (state_q != IDLE);
    assign step_count = stepCount_q;

endmodule

// File: tb/tb_lane_seq_gen.sv
// Bench for lane_seq_gen: hand-built vector table on two parameterisations, then random traffic vs a reference model.
module tb_lane_seq_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [2];
    logic       start [2];
    logic       stop [2];
    logic       ready [2];
    logic [7:0] laneA [2];
    logic [7:0] laneB [2];
    logic [7:0] laneC [2];
    logic [7:0] laneD [2];
    logic       valid [2];
    logic       busy [2];
    logic [15:0] stepCnt [2];

    lane_seq_gen #(.WIDTH(8), .INIT(5), .STEP_CYCLES(3)) dut0 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .stop(stop[0]), .out_ready(ready[0]),
        .a(laneA[0]), .b(laneB[0]), .c(laneC[0]), .d(laneD[0]),
        .out_valid(valid[0]), .busy(busy[0]), .step_count(stepCnt[0])
    );

    lane_seq_gen #(.WIDTH(8), .INIT(254), .STEP_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .stop(stop[1]), .out_ready(ready[1]),
        .a(laneA[1]), .b(laneB[1]), .c(laneC[1]), .d(laneD[1]),
        .out_valid(valid[1]), .busy(busy[1]), .step_count(stepCnt[1])
    );

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int         dut;
        int         cycles;
        logic       rst, start, stop, ready;
        logic [7:0] ea, eb, ec, ed;
        logic       ev, ebusy;
        logic [15:0] esc;
    } vec_t;

    vec_t vecs[$];

    // Reference model: lanes derived arithmetically from the number of steps since start.
    int         mInit [2] = '{5, 254};
    int         mCad  [2] = '{3, 1};
    bit         mActive [2];
    int         mSteps [2];
    int         mSince [2];
    bit         mValid [2];
    logic [7:0] mA [2], mB [2], mC [2], mD [2];

    function automatic vec_t mk(int dut, int cycles, logic r, logic s, logic p, logic rd,
                                logic [7:0] ea, logic [7:0] eb, logic [7:0] ec, logic [7:0] ed,
                                logic ev, logic ebusy, logic [15:0] esc);
        vec_t v;
        v.dut = dut; v.cycles = cycles;
        v.rst = r; v.start = s; v.stop = p; v.ready = rd;
        v.ea = ea; v.eb = eb; v.ec = ec; v.ed = ed;
        v.ev = ev; v.ebusy = ebusy; v.esc = esc;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input int i,
                               input logic [7:0] ea, input logic [7:0] eb,
                               input logic [7:0] ec, input logic [7:0] ed,
                               input logic ev, input logic ebusy, input logic [15:0] esc);
        checkVal({tag, " a"}, 32'(laneA[i]), 32'(ea));
        checkVal({tag, " b"}, 32'(laneB[i]), 32'(eb));
        checkVal({tag, " c"}, 32'(laneC[i]), 32'(ec));
        checkVal({tag, " d"}, 32'(laneD[i]), 32'(ed));
        checkVal({tag, " out_valid"}, 32'(valid[i]), 32'(ev));
        checkVal({tag, " busy"}, 32'(busy[i]), 32'(ebusy));
        checkVal({tag, " step_count"}, 32'(stepCnt[i]), 32'(esc));
    endtask

    task automatic applyStimulus(input int i, input int cycles,
                                 input logic r, input logic s, input logic p, input logic rd);
        rst[i] = r; start[i] = s; stop[i] = p; ready[i] = rd;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] laneVal(int i, int age);
        if (mSteps[i] < age) return 8'h00;
        return 8'(mInit[i] + mSteps[i] - age);
    endfunction

    task automatic modelEdge(input int i, input logic r, input logic s, input logic p, input logic rd);
        int nxt;
        if (r) begin
            mActive[i] = 0; mSteps[i] = 0; mSince[i] = 0; mValid[i] = 0;
            mA[i] = 0; mB[i] = 0; mC[i] = 0; mD[i] = 0;
        end else if (!mActive[i]) begin
            if (s) begin
                mActive[i] = 1; mSteps[i] = 0; mSince[i] = 0; mValid[i] = 0;
                mA[i] = laneVal(i, 0); mB[i] = 8'h00; mC[i] = 8'h00; mD[i] = 8'h00;
            end
        end else if (p) begin
            mActive[i] = 0; mValid[i] = 0;
        end else begin
            nxt = (mSince[i] + 1 > mCad[i]) ? mCad[i] : mSince[i] + 1;
            if (nxt >= mCad[i] && (!mValid[i] || rd)) begin
                mSteps[i]++;
                mSince[i] = 0;
                mA[i] = laneVal(i, 0); mB[i] = laneVal(i, 1);
                mC[i] = laneVal(i, 2); mD[i] = laneVal(i, 3);
                mValid[i] = (mSteps[i] >= 3);
            end else begin
                mSince[i] = nxt;
                if (mValid[i] && rd) mValid[i] = 0;
            end
        end
    endtask

    initial begin
        logic r [2], s [2], p [2], rd [2];
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; start[i] = 1'b0; stop[i] = 1'b0; ready[i] = 1'b0;
        end
        @(posedge clk);
        #1;

        // dut0: INIT=5, STEP_CYCLES=3
        vecs.push_back(mk(0, 1,  1,0,0,0, 8'd0,8'd0,8'd0,8'd0, 0,0,16'd0));
        vecs.push_back(mk(0, 10, 0,0,0,0, 8'd0,8'd0,8'd0,8'd0, 0,0,16'd0));
        vecs.push_back(mk(0, 1,  0,1,0,1, 8'd5,8'd0,8'd0,8'd0, 0,1,16'd0));
        vecs.push_back(mk(0, 8,  0,0,0,1, 8'd7,8'd6,8'd5,8'd0, 0,1,16'd2));
        vecs.push_back(mk(0, 1,  0,0,0,1, 8'd8,8'd7,8'd6,8'd5, 1,1,16'd3));
        vecs.push_back(mk(0, 3,  0,0,0,1, 8'd9,8'd8,8'd7,8'd6, 1,1,16'd4));
        vecs.push_back(mk(0, 1,  0,0,1,1, 8'd9,8'd8,8'd7,8'd6, 0,0,16'd4));
        vecs.push_back(mk(0, 1,  0,1,0,0, 8'd5,8'd0,8'd0,8'd0, 0,1,16'd0));
        vecs.push_back(mk(0, 8,  0,0,0,0, 8'd7,8'd6,8'd5,8'd0, 0,1,16'd2));
        vecs.push_back(mk(0, 1,  0,0,0,0, 8'd8,8'd7,8'd6,8'd5, 1,1,16'd3));
        vecs.push_back(mk(0, 11, 0,0,0,0, 8'd8,8'd7,8'd6,8'd5, 1,1,16'd3));
        vecs.push_back(mk(0, 1,  0,0,0,1, 8'd9,8'd8,8'd7,8'd6, 1,1,16'd4));
        vecs.push_back(mk(0, 1,  0,0,0,1, 8'd9,8'd8,8'd7,8'd6, 0,1,16'd4));
        vecs.push_back(mk(0, 1,  0,0,1,0, 8'd9,8'd8,8'd7,8'd6, 0,0,16'd4));
        vecs.push_back(mk(0, 1,  0,1,0,1, 8'd5,8'd0,8'd0,8'd0, 0,1,16'd0));
        vecs.push_back(mk(0, 3,  0,0,0,1, 8'd6,8'd5,8'd0,8'd0, 0,1,16'd1));
        vecs.push_back(mk(0, 1,  0,0,1,1, 8'd6,8'd5,8'd0,8'd0, 0,0,16'd1));
        vecs.push_back(mk(0, 2,  0,0,0,1, 8'd6,8'd5,8'd0,8'd0, 0,0,16'd1));
        vecs.push_back(mk(0, 1,  0,1,1,1, 8'd5,8'd0,8'd0,8'd0, 0,1,16'd0));
        vecs.push_back(mk(0, 8,  0,1,0,1, 8'd7,8'd6,8'd5,8'd0, 0,1,16'd2));
        vecs.push_back(mk(0, 1,  0,1,0,1, 8'd8,8'd7,8'd6,8'd5, 1,1,16'd3));
        vecs.push_back(mk(0, 1,  1,0,0,1, 8'd0,8'd0,8'd0,8'd0, 0,0,16'd0));
        vecs.push_back(mk(0, 1,  0,1,0,1, 8'd5,8'd0,8'd0,8'd0, 0,1,16'd0));
        vecs.push_back(mk(0, 9,  0,0,0,1, 8'd8,8'd7,8'd6,8'd5, 1,1,16'd3));
        vecs.push_back(mk(0, 2,  0,0,0,1, 8'd8,8'd7,8'd6,8'd5, 0,1,16'd3));
        vecs.push_back(mk(0, 1,  0,0,1,1, 8'd8,8'd7,8'd6,8'd5, 0,0,16'd3));
        // dut1: INIT=0xFE, STEP_CYCLES=1 (wrap-around, no bubbles)
        vecs.push_back(mk(1, 1,  1,0,0,0, 8'h00,8'h00,8'h00,8'h00, 0,0,16'd0));
        vecs.push_back(mk(1, 1,  0,1,0,1, 8'hFE,8'h00,8'h00,8'h00, 0,1,16'd0));
        vecs.push_back(mk(1, 3,  0,0,0,1, 8'h01,8'h00,8'hFF,8'hFE, 1,1,16'd3));
        vecs.push_back(mk(1, 1,  0,0,0,1, 8'h02,8'h01,8'h00,8'hFF, 1,1,16'd4));
        vecs.push_back(mk(1, 2,  0,0,0,0, 8'h02,8'h01,8'h00,8'hFF, 1,1,16'd4));
        vecs.push_back(mk(1, 1,  0,0,0,1, 8'h03,8'h02,8'h01,8'h00, 1,1,16'd5));
        vecs.push_back(mk(1, 1,  0,0,1,1, 8'h03,8'h02,8'h01,8'h00, 0,0,16'd5));

        foreach (vecs[n]) begin
            applyStimulus(vecs[n].dut, vecs[n].cycles,
                          vecs[n].rst, vecs[n].start, vecs[n].stop, vecs[n].ready);
            checkOutput($sformatf("vec%0d dut%0d", n, vecs[n].dut), vecs[n].dut,
                        vecs[n].ea, vecs[n].eb, vecs[n].ec, vecs[n].ed,
                        vecs[n].ev, vecs[n].ebusy, vecs[n].esc);
        end

        // Random traffic on both instances against the reference model.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                r[i]  = (cyc == 0) || ($urandom_range(0, 63) == 0);
                s[i]  = ($urandom_range(0, 7) == 0);
                p[i]  = ($urandom_range(0, 23) == 0);
                rd[i] = ($urandom_range(0, 1) == 1);
                rst[i] = r[i]; start[i] = s[i]; stop[i] = p[i]; ready[i] = rd[i];
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                modelEdge(i, r[i], s[i], p[i], rd[i]);
                checkOutput($sformatf("rand%0d dut%0d", cyc, i), i,
                            mA[i], mB[i], mC[i], mD[i], mValid[i], mActive[i],
                            16'((mSteps[i] > 65535) ? 65535 : mSteps[i]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lane_seq_gen.md
Name: lane_seq_gen

Overview:
Producer side of the four-lane a/b/c/d stimulus interface: the sequential source whose outputs a bench or downstream checker samples and compares. It generates a staggered counting sequence: lane a increments every step and older values shift a->b->c->d, so in steady state d = a-3. Results are offered with a valid/ready handshake, and the step cadence freezes under back-pressure. It sits under top as the generator feeding the output ports.

Parameters:
WIDTH, 8, lane width in bits.
INIT, 5, value loaded into lane a on start.
STEP_CYCLES, 3, clock cycles between steps; must be >=1.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  begin a sequence; sampled only in IDLE.
stop  input  1  abort the sequence and return to IDLE.
out_ready  input  1  consumer accepts the current a..d snapshot.
a  output  WIDTH  newest lane.
b  output  WIDTH  a delayed one step.
c  output  WIDTH  a delayed two steps.
d  output  WIDTH  a delayed three steps.
out_valid  output  1  a..d form a complete, unconsumed snapshot.
busy  output  1  state != IDLE.
step_count  output  16  steps taken since start; saturates at 0xFFFF.

Behaviour:
- Reset: rst high at an edge puts the block in IDLE. a=b=c=d=0, out_valid=0, busy=0, step_count=0, timer=0 and fill=0. This holds from any state; a mid-sequence reset drops the snapshot.
- FSM states: IDLE, FILL, RUN.
- IDLE: outputs hold their values. start=1 at edge k gives:
  - a=INIT, b=c=d=0, step_count=0, fill=0;
  - timer=STEP_CYCLES-1;
  - state FILL, busy=1 from k.
- Timer: decrements each cycle while nonzero. A step edge is an edge where the timer is 0 and (out_valid=0 or out_ready=1).
- Step edge actions:
  - a<=a+1 modulo 2^WIDTH; b<=a; c<=b; d<=c;
  - step_count+1 (saturating);
  - timer reloads STEP_CYCLES-1.
- Stall: timer is 0, out_valid=1 and out_ready=0. Timer, lanes and step_count freeze; snapshot stays stable.
- FILL: fill counts steps. On the 3rd step the state moves to RUN and out_valid becomes 1 at that edge. out_valid is always 0 in FILL, and out_ready is ignored there.
- RUN, without a step edge: if out_valid=1 and out_ready=1 at an edge, out_valid goes to 0 (consumed).
- RUN, step edge: out_valid becomes 1 with the new snapshot, even if the old one was accepted at the same edge. Simultaneous accept plus step means out_valid stays high with new data, so with out_ready tied high the cadence is exactly STEP_CYCLES.
- Step timing: with no stall, steps occur at k+n*STEP_CYCLES, n>=1.
- stop=1 in FILL or RUN: next state IDLE, out_valid=0, lanes hold. stop has priority over a coincident step.
- start while busy is ignored. start and stop together in IDLE: start wins.
- Wrap-around: all lane arithmetic is modulo 2^WIDTH with no saturation. Example: a=0xFF steps to a=0x00, b=0xFF.
- STEP_CYCLES=1: a step can occur every cycle. No bubble unless stalled.

Decomposition:
- lane_seq_pkg:
  - state enum {IDLE, FILL, RUN};
  - constants FILL_DEPTH=3 and STEP_CNT_W=16;
  - a saturating-increment function for step_count.
- One sub-module, lane_step_timer:
  - reload-able down counter with a freeze input;
  - outputs at_zero;
  - parameterised by STEP_CYCLES.
- The FSM and shift lanes stay in lane_seq_gen.

Test Plan:
- Reset values: hold rst for 1 cycle, then release -> a=b=c=d=0, out_valid=0, busy=0, step_count=0; stays unchanged for 10 cycles without start.
- Fill then steady state: defaults, start pulse at edge k, out_ready=1 -> out_valid first high at k+9 with a=8, b=7, c=6, d=5, step_count=3. At k+12: a=9, b=8, c=7, d=6, out_valid still 1.
- Back-pressure: as above but out_ready=0 from k+9 to k+20 -> a..d stay 8/7/6/5 and step_count stays 3. Raise out_ready at k+20 -> step at edge k+21 gives 9/8/7/6.
- Wrap-around: INIT=0xFE, STEP_CYCLES=1, out_ready=1 -> after 3 steps a=0x01, b=0x00, c=0xFF, d=0xFE.
- Stop and restart: stop pulse during FILL after 1 step -> IDLE, busy=0, out_valid=0, a=6, b=5. New start -> a=5, b=c=d=0, fill restarts, out_valid at +9.
- Reset mid-RUN: assert rst while out_valid=1 -> all outputs 0 next edge; start after release behaves as a fresh sequence.
